// File: rtl/dbg_regfile_ctrl_if.sv
// Debug host command channel for dbg_regfile_ctrl.
// The host side (vJTAG front-end) drives a level request with command fields
// held stable until the controller returns a one-cycle ack with read data and
// an error flag.
interface dbg_regfile_ctrl_if #(
  parameter int XLEN = 8
);
  logic            dbg_req;
  logic            dbg_we;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_wdata;
  logic            dbg_resume;
  logic            dbg_ack;
  logic [XLEN-1:0] dbg_rdata;
  logic            dbg_err;

  modport master (
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_resume,
    input  dbg_ack, dbg_rdata, dbg_err
  );

  modport slave (
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_resume,
    output dbg_ack, dbg_rdata, dbg_err
  );
endinterface

// File: rtl/dbg_regfile_ctrl.sv
// Debug-side controller for the 32-entry core register file.
// Halts the core on a debug command, borrows the regfile ports for exactly one
// cycle, returns the result, and keeps the core halted until the host resumes.
// Optional feature macro: DBG_WRITE_EN -- when defined, debug write commands
// update the regfile; when undefined they are acknowledged with an error.
module dbg_regfile_ctrl #(
  parameter int XLEN         = 8,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  dbg_regfile_ctrl_if.slave dbg,
  output logic              core_halt_req,
  input  logic              core_halted,
  input  logic [4:0]        core_rf_raddr,
  output logic [XLEN-1:0]   core_rf_rdata,
  input  logic              core_rf_we,
  input  logic [4:0]        core_rf_waddr,
  input  logic [XLEN-1:0]   core_rf_wdata,
  output logic [4:0]        rf_raddr,
  input  logic [XLEN-1:0]   rf_rdata,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [XLEN-1:0]   rf_wdata
);

`ifdef DBG_WRITE_EN
  localparam bit WRITE_ENABLED = 1'b1;
`else
  localparam bit WRITE_ENABLED = 1'b0;
`endif

  localparam logic [7:0] TIMEOUT_CNT = 8'(HALT_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    HALTING,
    HALTED,
    ACCESS,
    RESP
  } state_t;

  state_t          state;
  logic [7:0]      halt_cnt;
  logic            timed_out;
  logic            ack_q;
  logic            err_q;
  logic [XLEN-1:0] rdata_q;

  // Command sequencer: halt, one-cycle access, registered response, resume.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      halt_cnt      <= '0;
      timed_out     <= 1'b0;
      core_halt_req <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (dbg.dbg_req) begin
            state         <= HALTING;
            core_halt_req <= 1'b1;
            halt_cnt      <= '0;
          end
        end
        HALTING: begin
          if (core_halted) begin
            state <= ACCESS;
          end else if (halt_cnt == TIMEOUT_CNT) begin
            state         <= RESP;
            ack_q         <= 1'b1;
            err_q         <= 1'b1;
            core_halt_req <= 1'b0;
            timed_out     <= 1'b1;
          end else begin
            halt_cnt <= halt_cnt + 8'd1;
          end
        end
        HALTED: begin
          if (dbg.dbg_req) begin
            state <= ACCESS;
          end else if (dbg.dbg_resume) begin
            state         <= IDLE;
            core_halt_req <= 1'b0;
          end
        end
        ACCESS: begin
          state <= RESP;
          ack_q <= 1'b1;
          if (dbg.dbg_we) begin
            err_q <= ~WRITE_ENABLED;
          end else begin
            rdata_q <= (dbg.dbg_addr == 5'd0) ? '0 : rf_rdata;
          end
        end
        RESP: begin
          state     <= timed_out ? IDLE : HALTED;
          timed_out <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Regfile port mux: debug owns both ports only during ACCESS, x0 is never written.
  always_comb begin
    rf_raddr = core_rf_raddr;
    rf_we    = core_rf_we;
    rf_waddr = core_rf_waddr;
    rf_wdata = core_rf_wdata;
    if (state == ACCESS) begin
      rf_raddr = dbg.dbg_addr;
      rf_waddr = dbg.dbg_addr;
      rf_wdata = dbg.dbg_wdata;
      rf_we    = WRITE_ENABLED && dbg.dbg_we && (dbg.dbg_addr != 5'd0);
    end
  end

  assign core_rf_rdata = rf_rdata;
  assign dbg.dbg_ack   = ack_q;
  assign dbg.dbg_err   = err_q;
  assign dbg.dbg_rdata = rdata_q;

endmodule

// File: tb/tb_dbg_regfile_ctrl.sv
// Testbench for dbg_regfile_ctrl: directed vectors with hand-computed results.
// Expected values follow the DBG_WRITE_EN build setting of this compile.
module tb_dbg_regfile_ctrl;

`ifdef DBG_WRITE_EN
  localparam bit WE_ON = 1'b1;
`else
  localparam bit WE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       core_halt_req;
  logic       core_halted;
  logic [4:0] core_rf_raddr = '0;
  logic [7:0] core_rf_rdata;
  logic       core_rf_we = 1'b0;
  logic [4:0] core_rf_waddr = '0;
  logic [7:0] core_rf_wdata = '0;
  logic [4:0] rf_raddr;
  logic [7:0] rf_rdata;
  logic       rf_we;
  logic [4:0] rf_waddr;
  logic [7:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  dbg_regfile_ctrl_if #(.XLEN(8)) dbg_bus ();

  dbg_regfile_ctrl #(.XLEN(8), .HALT_TIMEOUT(255)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dbg           (dbg_bus),
    .core_halt_req (core_halt_req),
    .core_halted   (core_halted),
    .core_rf_raddr (core_rf_raddr),
    .core_rf_rdata (core_rf_rdata),
    .core_rf_we    (core_rf_we),
    .core_rf_waddr (core_rf_waddr),
    .core_rf_wdata (core_rf_wdata),
    .rf_raddr      (rf_raddr),
    .rf_rdata      (rf_rdata),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata)
  );

  always #5 clk = ~clk;

  // Core model: halted asserts in the third cycle of a continuous halt request.
  logic [1:0] halt_sr = '0;
  logic       core_en = 1'b1;
  always @(posedge clk) begin
    if (!core_halt_req) halt_sr <= 2'b00;
    else                halt_sr <= {halt_sr[0], 1'b1};
  end
  assign core_halted = halt_sr[1] & core_en;

  // Regfile model with asynchronous read and known preload on reset.
  logic [7:0] rf [32];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= 8'h00;
      rf[0]  <= 8'h99;
      rf[5]  <= 8'h3C;
      rf[7]  <= 8'h11;
      rf[31] <= 8'hC3;
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_rdata = rf[rf_raddr];

  // Write-pulse monitor.
  int         we_pulses = 0;
  logic [4:0] last_waddr = '0;
  logic [7:0] last_wdata = '0;
  always @(posedge clk) begin
    if (rst_n && rf_we) begin
      we_pulses  <= we_pulses + 1;
      last_waddr <= rf_waddr;
      last_wdata <= rf_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                               input int limit, output int edges,
                               output logic [7:0] rdata, output logic err);
    logic got;
    dbg_bus.dbg_we    = we;
    dbg_bus.dbg_addr  = addr;
    dbg_bus.dbg_wdata = wdata;
    dbg_bus.dbg_req   = 1'b1;
    edges = 0;
    got   = 1'b0;
    while (!got && edges < limit) begin
      @(posedge clk);
      #1;
      edges++;
      got = dbg_bus.dbg_ack;
    end
    rdata = dbg_bus.dbg_rdata;
    err   = dbg_bus.dbg_err;
    if (!got) checkOutput("ack_timeout", 32'(got), 32'd1);
    dbg_bus.dbg_req = 1'b0;
    dbg_bus.dbg_we  = 1'b0;
  endtask

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_pulses;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int         edges;
    logic [7:0] rd;
    logic       er;
    int         pulses0;
    int         access_cycles;
    logic       acked;

    vecs[0] = '{1'b0, 5'd5,  8'h00, 8'h3C,                      1'b0,   0};
    vecs[1] = '{1'b1, 5'd7,  8'hA5, 8'h3C,                      ~WE_ON, WE_ON ? 1 : 0};
    vecs[2] = '{1'b0, 5'd7,  8'h00, WE_ON ? 8'hA5 : 8'h11,      1'b0,   0};
    vecs[3] = '{1'b1, 5'd0,  8'hFF, WE_ON ? 8'hA5 : 8'h11,      ~WE_ON, 0};
    vecs[4] = '{1'b0, 5'd0,  8'h00, 8'h00,                      1'b0,   0};
    vecs[5] = '{1'b1, 5'd31, 8'h5A, 8'h00,                      ~WE_ON, WE_ON ? 1 : 0};
    vecs[6] = '{1'b0, 5'd31, 8'h00, WE_ON ? 8'h5A : 8'hC3,      1'b0,   0};

    dbg_bus.dbg_req    = 1'b0;
    dbg_bus.dbg_we     = 1'b0;
    dbg_bus.dbg_addr   = '0;
    dbg_bus.dbg_wdata  = '0;
    dbg_bus.dbg_resume = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_halt_req", 32'(core_halt_req), 32'd0);
    checkOutput("reset_ack", 32'(dbg_bus.dbg_ack), 32'd0);
    checkOutput("reset_err", 32'(dbg_bus.dbg_err), 32'd0);
    checkOutput("reset_rdata", 32'(dbg_bus.dbg_rdata), 32'd0);
    checkOutput("reset_rf_we", 32'(rf_we), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] read x5 with core running");
    applyStimulus(1'b0, 5'd5, 8'h00, 20, edges, rd, er);
    checkOutput("run_read_latency", 32'(edges), 32'd5);
    checkOutput("run_read_rdata", 32'(rd), 32'h3C);
    checkOutput("run_read_err", 32'(er), 32'd0);
    checkOutput("run_read_halt_req", 32'(core_halt_req), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("run_read_halt_hold", 32'(core_halt_req), 32'd1);

    $display("[TB] halted-core vector table");
    for (int i = 0; i < 7; i++) begin
      pulses0 = we_pulses;
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, 10, edges, rd, er);
      checkOutput($sformatf("vec%0d_latency", i), 32'(edges), 32'd2);
      checkOutput($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
      checkOutput($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_ack_pulse", i), 32'(dbg_bus.dbg_ack), 32'd0);
      checkOutput($sformatf("vec%0d_we_pulses", i), 32'(we_pulses - pulses0), 32'(vecs[i].exp_pulses));
      if (vecs[i].exp_pulses == 1) begin
        checkOutput($sformatf("vec%0d_waddr", i), 32'(last_waddr), 32'(vecs[i].addr));
        checkOutput($sformatf("vec%0d_wdata", i), 32'(last_wdata), 32'(vecs[i].wdata));
      end
    end

    $display("[TB] request and resume in the same halted cycle");
    dbg_bus.dbg_resume = 1'b1;
    dbg_bus.dbg_we     = 1'b0;
    dbg_bus.dbg_addr   = 5'd5;
    dbg_bus.dbg_req    = 1'b1;
    @(posedge clk);
    #1;
    dbg_bus.dbg_resume = 1'b0;
    applyStimulus(1'b0, 5'd5, 8'h00, 10, edges, rd, er);
    checkOutput("req_resume_latency", 32'(edges), 32'd1);
    checkOutput("req_resume_rdata", 32'(rd), 32'h3C);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("req_resume_still_halted", 32'(core_halt_req), 32'd1);
    dbg_bus.dbg_resume = 1'b1;
    @(posedge clk);
    #1;
    dbg_bus.dbg_resume = 1'b0;
    checkOutput("resume_drops_halt", 32'(core_halt_req), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] halt timeout");
    core_en = 1'b0;
    applyStimulus(1'b0, 5'd5, 8'h00, 300, edges, rd, er);
    checkOutput("timeout_latency", 32'(edges), 32'd257);
    checkOutput("timeout_err", 32'(er), 32'd1);
    checkOutput("timeout_rdata_kept", 32'(rd), 32'h3C);
    checkOutput("timeout_halt_req", 32'(core_halt_req), 32'd0);
    @(posedge clk);
    #1;
    core_en = 1'b1;
    applyStimulus(1'b0, 5'd7, 8'h00, 20, edges, rd, er);
    checkOutput("after_timeout_latency", 32'(edges), 32'd5);
    checkOutput("after_timeout_rdata", 32'(rd), WE_ON ? 32'hA5 : 32'h11);
    @(posedge clk);
    #1;
    dbg_bus.dbg_resume = 1'b1;
    @(posedge clk);
    #1;
    dbg_bus.dbg_resume = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset during halting");
    core_en = 1'b0;
    dbg_bus.dbg_addr = 5'd5;
    dbg_bus.dbg_we   = 1'b0;
    dbg_bus.dbg_req  = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("halting_halt_req", 32'(core_halt_req), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    dbg_bus.dbg_req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset_halt_req", 32'(core_halt_req), 32'd0);
    checkOutput("midreset_ack", 32'(dbg_bus.dbg_ack), 32'd0);
    checkOutput("midreset_err", 32'(dbg_bus.dbg_err), 32'd0);
    checkOutput("midreset_rdata", 32'(dbg_bus.dbg_rdata), 32'd0);
    rst_n = 1'b1;
    acked = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (dbg_bus.dbg_ack) acked = 1'b1;
    end
    checkOutput("midreset_no_ack", 32'(acked), 32'd0);

    core_en       = 1'b1;
    core_rf_we    = 1'b1;
    core_rf_waddr = 5'd9;
    core_rf_wdata = 8'h42;
    #1;
    checkOutput("core_pass_we", 32'(rf_we), 32'd1);
    checkOutput("core_pass_waddr", 32'(rf_waddr), 32'd9);
    checkOutput("core_pass_wdata", 32'(rf_wdata), 32'h42);
    @(posedge clk);
    #1;
    core_rf_raddr = 5'd9;
    #1;
    checkOutput("core_pass_rdata", 32'(core_rf_rdata), 32'h42);

    $display("[TB] core write blocked during debug access");
    core_rf_waddr   = 5'd10;
    core_rf_wdata   = 8'h66;
    dbg_bus.dbg_addr = 5'd9;
    dbg_bus.dbg_we   = 1'b0;
    dbg_bus.dbg_req  = 1'b1;
    access_cycles = 0;
    acked = 1'b0;
    for (int e = 0; e < 10 && !acked; e++) begin
      @(posedge clk);
      #1;
      if (!rf_we) begin
        access_cycles++;
        checkOutput("access_raddr", 32'(rf_raddr), 32'd9);
      end
      if (dbg_bus.dbg_ack) begin
        acked = 1'b1;
        rd = dbg_bus.dbg_rdata;
      end
    end
    dbg_bus.dbg_req = 1'b0;
    core_rf_we = 1'b0;
    checkOutput("access_acked", 32'(acked), 32'd1);
    checkOutput("access_blocked_cycles", 32'(access_cycles), 32'd1);
    checkOutput("access_rdata", 32'(rd), 32'h42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
